// File: rtl/mem_rw_arbiter.sv
// mem_rw_arbiter: round-robin arbiter with stall hold and lock, multiplexing
// NREQ requesters onto one main-memory read/write port.
module mem_rw_arbiter #(
  parameter int NREQ = 3,
  parameter int AW = 8,
  parameter int DW = 16,
  localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_val_i,
  input  logic [NREQ-1:0]   req_wen_i,
  input  logic [NREQ-1:0]   req_lock_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]   req_rdy_o,
  output logic [NREQ-1:0]   resp_val_o,
  output logic [DW-1:0]     resp_rdata_o,
  output logic              mem_val_o,
  output logic              mem_wen_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  input  logic [DW-1:0]     mem_rdata_i,
  input  logic              mem_rdy_i,
  output logic [GW-1:0]     grant_o,
  output logic              locked_o
);
  typedef enum logic [1:0] {IDLE, STALL, LOCKED} state_t;
  state_t state;
  logic [GW-1:0] own, ptr, rr, grant;
  logic xfer, rd_xfer;
  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    rr = ptr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_val_i[(int'(ptr) + k) % NREQ]) rr = GW'((int'(ptr) + k) % NREQ);
  end
  assign grant = (state == IDLE) ? rr : own;
  assign mem_val_o = !rst_i && req_val_i[grant];
  assign mem_wen_o = req_wen_i[grant];
  assign mem_addr_o = req_addr_i[int'(grant)*AW +: AW];
  assign mem_wdata_o = req_wdata_i[int'(grant)*DW +: DW];
  assign req_rdy_o = rst_i ? '0 : NREQ'(mem_rdy_i) << grant;
  assign xfer = mem_val_o && mem_rdy_i;
  assign rd_xfer = xfer && !mem_wen_o;
  assign grant_o = grant;
  assign locked_o = state == LOCKED;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      own <= '0;
      ptr <= '0;
      resp_val_o <= '0;
      resp_rdata_o <= '0;
    end else begin
      resp_val_o <= rd_xfer ? NREQ'(1) << grant : '0;
      resp_rdata_o <= rd_xfer ? mem_rdata_i : '0;
      if (xfer) begin
        state <= req_lock_i[grant] ? LOCKED : IDLE;
        own <= grant;
        ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
      end else if (state == IDLE && mem_val_o) begin
        state <= STALL;
        own <= grant;
      end
    end
endmodule

// File: doc/mem_rw_arbiter.md
MEM_RW_ARBITER -- requirements
Module: mem_rw_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, number of requesters (0 = core, 1 = front panel, 2 = stdout dump).
REQ-002 The block SHALL have parameter AW, default 8, memory address width.
REQ-003 The block SHALL have parameter DW, default 16, memory data width.
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 req_val_i  in  NREQ  per-requester access request.
REQ-007 req_wen_i  in  NREQ  per-requester write enable (0 = read).
REQ-008 req_lock_i  in  NREQ  per-requester lock, keeps grant after the current transfer.
REQ-009 req_addr_i  in  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW].
REQ-010 req_wdata_i  in  NREQ*DW  packed write data, same packing.
REQ-011 req_rdy_o  out  NREQ  accept, one-hot or zero.
REQ-012 resp_val_o  out  NREQ  read-data valid, one-hot or zero.
REQ-013 resp_rdata_o  out  DW  shared read data.
REQ-014 mem_val_o, mem_wen_o  out  1 each  request to the main memory rw port.
REQ-015 mem_addr_o  out  AW, and mem_wdata_o  out  DW, to the main memory rw port.
REQ-016 mem_rdata_i  in  DW, and mem_rdy_i  in  1, from the main memory rw port.
REQ-017 grant_o  out  $clog2(NREQ)  index of the current owner, for debug.
REQ-018 locked_o  out  1  high while state is LOCKED.

Function
REQ-019 Transfer definition: a transfer SHALL occur in any cycle with mem_val_o && mem_rdy_i.
REQ-020 States SHALL be IDLE, STALL and LOCKED, with owner register own and round-robin pointer ptr.
REQ-021 IDLE grant: grant SHALL be the first i with req_val_i[i], scanning ptr, ptr+1, ... modulo NREQ.
REQ-022 IDLE with no request: mem_val_o SHALL be 0.
REQ-023 STALL and LOCKED grant: grant SHALL equal own regardless of other requests.
REQ-024 The mem_* outputs SHALL combinationally forward the granted requester's val, wen, addr and wdata.
REQ-025 req_rdy_o[grant] SHALL equal mem_rdy_i; all other req_rdy_o bits SHALL be 0.
REQ-026 IDLE -> STALL when mem_val_o && !mem_rdy_i; own <= grant; request SHALL be held stable until transfer.
REQ-027 IDLE or STALL -> LOCKED on a transfer with req_lock_i[grant]=1; own <= grant.
REQ-028 LOCKED SHALL persist while the owner has req_lock_i[own]=1 on its transfers.
REQ-029 LOCKED with owner req_val_i low SHALL keep mem_val_o=0 and stay LOCKED.
REQ-030 Exit to IDLE SHALL occur on a transfer with req_lock_i[grant]=0, from IDLE, STALL or LOCKED.
REQ-031 Pointer update: every transfer SHALL set ptr <= (grant+1) mod NREQ, wrapping NREQ-1 -> 0.
REQ-032 Read response: a read transfer SHALL pulse resp_val_o[grant] exactly the next cycle with resp_rdata_o = mem_rdata_i.
REQ-033 Write transfers SHALL produce no resp_val_o.
REQ-034 Back-to-back reads SHALL be supported, one response per cycle in transfer order.
REQ-035 resp_rdata_o SHALL be 0 whenever resp_val_o is 0.
REQ-036 A lone requester SHALL be granted every cycle; no idle bubble SHALL be inserted between its transfers.

Reset
REQ-037 While rst_i is high: state=IDLE, ptr=0, own=0, resp_val_o=0, locked_o=0, mem_val_o=0, req_rdy_o=0.
REQ-038 Reset mid-STALL or mid-LOCKED SHALL drop the grant, and any pending read response SHALL be discarded (no resp_val_o after release).
REQ-039 The first cycle after reset release SHALL arbitrate from requester 0.

Verification
REQ-040 Round-robin: all 3 requesters read continuously, mem_rdy_i=1 -> grants 0,1,2,0,1,2; each resp_val_o one cycle after its own req_rdy_o.
REQ-041 Stall: req 1 reads 0x10, mem_rdy_i low 3 cycles, req 0 raised meanwhile -> grant stays 1; on mem_rdy_i high, resp_rdata_o=mem[0x10] to requester 1; next grant 2 or 0 per ptr=2.
REQ-042 Lock: req 0 writes 0x20..0x23 with lock=1 except the last, req 2 requesting throughout -> req 2 blocked for 4 transfers, granted on the 5th cycle.
REQ-043 Locked gap: owner drops val 2 cycles inside the lock -> mem_val_o=0 and the other requesters stay blocked.
REQ-044 Write then read: req 1 writes 0xBEEF to 0x05, then reads 0x05 -> no response for the write; resp_rdata_o=0xBEEF on the cycle after the read transfer.
REQ-045 Reset: rst_i asserted the cycle after a read transfer -> no resp_val_o; after release ptr=0 and locked_o=0.
